pll_dri_master: RTL and testbench
=================================

# pll_dri_master

Dynamic-reconfiguration initiator for the PolarFire PLL. It turns single register read/write commands from the fabric into transactions on the PLL's DRI port (DRI_CTRL, DRI_WDATA, DRI_RDATA), waits for each completion, and returns read data and a status code. It sits in the processor subsystem next to the clock-conditioning block, so firmware can retune the PLL without a new bitstream.

## Interface
Clock is `DRI_CLK`; reset is `DRI_ARST_N`. Reset is asynchronous and active-low (already decided).

Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for a DRI acknowledge.
- `LOCK_TIMEOUT_CYCLES`, 65535: maximum cycles to wait for the PLL to relock after a write.
- `CNT_W`, 16: timeout counter width. It must hold both timeout values.

Ports:
- `DRI_CLK` in 1: DRI clock; all logic runs on it.
- `DRI_ARST_N` in 1: asynchronous active-low reset.
- `CMD_VALID` in 1: command request.
- `CMD_READY` out 1: command accepted when both `CMD_VALID` and `CMD_READY` are high.
- `CMD_WRITE` in 1: 1 = write, 0 = read.
- `CMD_ADDR` in 9: PLL register address.
- `CMD_WDATA` in 32: write data.
- `RSP_VALID` out 1: response available.
- `RSP_READY` in 1: response consumed.
- `RSP_RDATA` out 32: read data (0 for writes).
- `RSP_ERR` out 2: 00 ok, 01 acknowledge timeout, 10 relock timeout.
- `BUSY` out 1: high whenever the FSM is not in IDLE.
- `DRI_CTRL` out 11: `{addr[8:0], rw, req}`.
- `DRI_WDATA` out 33: `{commit, data[31:0]}`.
- `DRI_RDATA` in 33: `{ack, data[31:0]}`.
- `DRI_INTERRUPT` in 1: PLL event flag, synchronised internally and latched.
- `PLL_LOCK` in 1: asynchronous; passed through a 2-flop synchroniser inside the block.

## Operation
- FSM states: IDLE, REQ, WAIT_ACK, RELOCK, RESP.
- IDLE:
  - `CMD_READY` = 1.
  - On handshake, register addr, rw and data, clear the counter, and go to REQ.
- REQ:
  - Drive `DRI_CTRL.req` = 1 for exactly one cycle.
  - `commit` = `rw`.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - The counter increments every cycle.
  - On `DRI_RDATA[32]` = 1: capture `DRI_RDATA[31:0]` if reading. Go to RELOCK for a write (when relock wait is enabled), otherwise go to RESP with ERR = 00.
  - On counter == `TIMEOUT_CYCLES` with no ack: go to RESP with ERR = 01. No retry.
- RELOCK:
  - Clear the counter on entry.
  - Wait for a synchronised `PLL_LOCK` falling edge followed by a rising edge; the response is ERR = 00.
  - On counter == `LOCK_TIMEOUT_CYCLES`: ERR = 10.
- RESP:
  - Hold `RSP_VALID` and the payload until `RSP_READY`, then return to IDLE.
- `DRI_INTERRUPT` rising edge sets an internal sticky flag. A read of address `9'h1FF` is serviced locally: it returns `{31'b0, flag}` in RESP one cycle after acceptance, clears the flag, and issues no DRI transaction.
- `DRI_CTRL` and `DRI_WDATA` are all-zero outside REQ; they are register outputs (no glitches).

## Timing
- Reset values:
  - `CMD_READY` = 1 (from the first cycle after reset release; 0 while reset is asserted).
  - `RSP_VALID` = 0, `RSP_RDATA` = 0, `RSP_ERR` = 0, `BUSY` = 0.
  - `DRI_CTRL` = 0, `DRI_WDATA` = 0.
  - Sync flops = 0, counter = 0, interrupt flag = 0.
- For a command accepted at cycle T: `req` is high at T+1; ack is sampled from T+2.
- Ack seen at cycle A: `RSP_VALID` = 1 at A+1 (no relock path).
- Ack arriving in the same cycle the counter reaches the limit: the ack wins (ERR = 00).
- Ack arriving outside WAIT_ACK is ignored.
- `CMD_READY` = 0 from T+1 until the cycle after the response handshake. This allows one command in flight only.
- `PLL_LOCK` has 2 cycles of synchroniser latency; edges are detected on the synchronised value.
- Reset asserted mid-transaction aborts immediately to IDLE. No response is produced; `DRI_CTRL` drops to 0 asynchronously.

## Configuration
- `PLL_DRI_RELOCK_WAIT_EN` defined: writes pass through RELOCK as described.
- `PLL_DRI_RELOCK_WAIT_EN` undefined:
  - The RELOCK state, lock synchroniser and lock counter logic are not compiled.
  - Writes go from ack straight to RESP.
  - ERR = 10 is never produced.
  - `PLL_LOCK` stays in the port list unused.

## Structure
- The shared package `pll_dri_pkg` holds:
  - the FSM state enum;
  - the `RSP_ERR` codes (`ERR_OK`, `ERR_ACK_TO`, `ERR_LOCK_TO`);
  - the `DRI_CTRL`/`DRI_WDATA`/`DRI_RDATA` bit-position constants;
  - the local status address `9'h1FF`.
- Sub-module `pll_dri_sync2`: a 2-flop synchroniser with async clear, used for `PLL_LOCK` and `DRI_INTERRUPT`.

## Test plan
- Read addr `9'h004`, responder acks 3 cycles after `req` with data `32'hA5A5_0001` -> `RSP_RDATA` = `32'hA5A5_0001`, ERR = 00, `req` pulse exactly 1 cycle wide.
- Write addr `9'h010`, data `32'h0000_00F9`, relock enabled; lock drops and returns after 100 cycles -> `DRI_WDATA` = `{1, 32'hF9}`, response ERR = 00 no earlier than the lock rise plus 2 cycles.
- No ack, `TIMEOUT_CYCLES` = 255 -> ERR = 01 at exactly T+2+255 (±1, per the documented counter); `CMD_READY` = 1 after the response is accepted.
- Write with lock never returning, `LOCK_TIMEOUT_CYCLES` = 1000 -> ERR = 10; with the macro undefined, the same stimulus gives ERR = 00 directly after the ack.
- Pulse `DRI_INTERRUPT`, then read `9'h1FF` twice -> returns 1, then 0; `DRI_CTRL` stays 0 throughout.
- Assert `DRI_ARST_N` low during WAIT_ACK -> all outputs at reset values immediately; the next command completes normally.

Source files
------------

// File: rtl/pll_dri_pkg.sv
// Shared types and constants for the PolarFire PLL DRI initiator.
// The build option PLL_DRI_RELOCK_WAIT_EN is consumed by pll_dri_master.
package pll_dri_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RELOCK   = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ACK_TO  = 2'b01;
    localparam logic [1:0] ERR_LOCK_TO = 2'b10;

    localparam int ADDR_W           = 9;
    localparam int DATA_W           = 32;
    localparam int CTRL_REQ_BIT     = 0;
    localparam int CTRL_RW_BIT      = 1;
    localparam int CTRL_ADDR_LSB    = 2;
    localparam int WDATA_COMMIT_BIT = 32;
    localparam int RDATA_ACK_BIT    = 32;

    localparam logic [ADDR_W-1:0] STATUS_ADDR = 9'h1FF;

endpackage

// File: rtl/pll_dri_sync2.sv
// Two-flop synchroniser with asynchronous clear for single-bit async inputs.
module pll_dri_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_dri_master.sv
// DRI initiator: one fabric read/write command at a time onto the PLL DRI port.
// Define PLL_DRI_RELOCK_WAIT_EN to make writes wait for the PLL to relock.
import pll_dri_pkg::*;

module pll_dri_master #(
    parameter int TIMEOUT_CYCLES      = 255,
    parameter int LOCK_TIMEOUT_CYCLES = 65535,
    parameter int CNT_W               = 16
) (
    input  logic        DRI_CLK,
    input  logic        DRI_ARST_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [8:0]  CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic [1:0]  RSP_ERR,
    output logic        BUSY,
    output logic [10:0] DRI_CTRL,
    output logic [32:0] DRI_WDATA,
    input  logic [32:0] DRI_RDATA,
    input  logic        DRI_INTERRUPT,
    input  logic        PLL_LOCK
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rw_q;
    logic             ack;
    logic             int_s, int_prev, int_flag, int_rise;

    assign ack      = DRI_RDATA[RDATA_ACK_BIT];
    assign BUSY     = (state != ST_IDLE);
    assign int_rise = int_s & ~int_prev;

    pll_dri_sync2 u_int_sync (
        .clk   (DRI_CLK),
        .rst_n (DRI_ARST_N),
        .d     (DRI_INTERRUPT),
        .q     (int_s)
    );

`ifdef PLL_DRI_RELOCK_WAIT_EN
    logic lock_s, lock_prev, lock_fell, lock_rise, lock_fall;

    pll_dri_sync2 u_lock_sync (
        .clk   (DRI_CLK),
        .rst_n (DRI_ARST_N),
        .d     (PLL_LOCK),
        .q     (lock_s)
    );

    assign lock_rise = lock_s & ~lock_prev;
    assign lock_fall = ~lock_s & lock_prev;
`else
    logic unused_cfg;
    assign unused_cfg = ^{PLL_LOCK, ERR_LOCK_TO, LOCK_TIMEOUT_CYCLES[0]};
`endif

    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rw_q      <= 1'b0;
            int_prev  <= 1'b0;
            int_flag  <= 1'b0;
            CMD_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= ERR_OK;
            DRI_CTRL  <= '0;
            DRI_WDATA <= '0;
`ifdef PLL_DRI_RELOCK_WAIT_EN
            lock_prev <= 1'b0;
            lock_fell <= 1'b0;
`endif
        end else begin
            // DRI outputs are zero except for the single REQ cycle loaded below
            DRI_CTRL  <= '0;
            DRI_WDATA <= '0;
            int_prev  <= int_s;
`ifdef PLL_DRI_RELOCK_WAIT_EN
            lock_prev <= lock_s;
`endif
            unique case (state)
                ST_IDLE: begin
                    CMD_READY <= 1'b1;
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        rw_q      <= CMD_WRITE;
                        cnt       <= '0;
                        if (!CMD_WRITE && CMD_ADDR == STATUS_ADDR) begin
                            RSP_VALID <= 1'b1;
                            RSP_RDATA <= {31'b0, int_flag};
                            RSP_ERR   <= ERR_OK;
                            int_flag  <= 1'b0;
                            state     <= ST_RESP;
                        end else begin
                            DRI_CTRL[CTRL_ADDR_LSB +: ADDR_W] <= CMD_ADDR;
                            DRI_CTRL[CTRL_RW_BIT]             <= CMD_WRITE;
                            DRI_CTRL[CTRL_REQ_BIT]            <= 1'b1;
                            DRI_WDATA[WDATA_COMMIT_BIT]       <= CMD_WRITE;
                            DRI_WDATA[DATA_W-1:0]             <= CMD_WRITE ? CMD_WDATA : '0;
                            state                             <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    cnt <= cnt + CNT_W'(1);
                    // an ack in the limit cycle still completes normally
                    if (ack) begin
`ifdef PLL_DRI_RELOCK_WAIT_EN
                        if (rw_q) begin
                            cnt       <= '0;
                            lock_fell <= 1'b0;
                            state     <= ST_RELOCK;
                        end else
`endif
                        begin
                            RSP_VALID <= 1'b1;
                            RSP_RDATA <= rw_q ? '0 : DRI_RDATA[DATA_W-1:0];
                            RSP_ERR   <= ERR_OK;
                            state     <= ST_RESP;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        RSP_VALID <= 1'b1;
                        RSP_RDATA <= '0;
                        RSP_ERR   <= ERR_ACK_TO;
                        state     <= ST_RESP;
                    end
                end
`ifdef PLL_DRI_RELOCK_WAIT_EN
                ST_RELOCK: begin
                    cnt <= cnt + CNT_W'(1);
                    if (lock_fall)
                        lock_fell <= 1'b1;
                    if (lock_fell && lock_rise) begin
                        RSP_VALID <= 1'b1;
                        RSP_RDATA <= '0;
                        RSP_ERR   <= ERR_OK;
                        state     <= ST_RESP;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES)) begin
                        RSP_VALID <= 1'b1;
                        RSP_RDATA <= '0;
                        RSP_ERR   <= ERR_LOCK_TO;
                        state     <= ST_RESP;
                    end
                end
`endif
                ST_RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        RSP_RDATA <= '0;
                        RSP_ERR   <= ERR_OK;
                        CMD_READY <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // a new interrupt edge beats a same-cycle status-read clear
            if (int_rise)
                int_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_dri_master.sv
// Bench for pll_dri_master: directed and randomised commands against a behavioural model.
module tb_pll_dri_master;

    localparam int TO  = 255;
    localparam int LTO = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [8:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [10:0] dri_ctrl;
    logic [32:0] dri_wdata;
    logic [32:0] dri_rdata;
    logic        dri_interrupt = 1'b0;
    logic        pll_lock;

    always #5 clk = ~clk;

    pll_dri_master #(.TIMEOUT_CYCLES(TO), .LOCK_TIMEOUT_CYCLES(LTO), .CNT_W(16)) dut (
        .DRI_CLK(clk), .DRI_ARST_N(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
        .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .BUSY(busy), .DRI_CTRL(dri_ctrl), .DRI_WDATA(dri_wdata), .DRI_RDATA(dri_rdata),
        .DRI_INTERRUPT(dri_interrupt), .PLL_LOCK(pll_lock)
    );

    int checks = 0, passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PLL-side responder state
    int          ack_delay = 0, pend = 0;
    logic [31:0] ack_data = '0;
    int          lock_mode = 0, lock_gap = 0, lock_t = 0, rise_cyc = -1;
    bit          stray_ack = 1'b0;
    int          req_cnt = 0, req_width = 0, max_width = 0;
    logic [10:0] last_ctrl = '0;
    logic [32:0] last_wdata = '0;
    bit          flag_model = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic check_range(input string tag, input int v, input int lo, input int hi);
        checks++;
        assert (v >= lo && v <= hi) passes++;
        else $error("FAIL %s: got %0d, want %0d..%0d", tag, v, lo, hi);
    endtask

    // Responder: acks ack_delay cycles after req, then optionally drops and restores lock
    initial begin : responder
        dri_rdata = '0;
        pll_lock  = 1'b1;
        forever begin
            @(negedge clk);
            dri_rdata = '0;
            if (stray_ack) begin
                dri_rdata = {1'b1, 32'hDEAD_BEEF};
                stray_ack = 1'b0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    dri_rdata = {1'b1, ack_data};
                    if (lock_mode != 0) lock_t = 1;
                end
            end
            if (lock_t > 0) begin
                lock_t++;
                if (lock_t == 6) pll_lock = 1'b0;
                if (lock_mode == 2 && lock_t == 6) lock_t = 0;
                else if (lock_mode == 1 && lock_t == 6 + lock_gap) begin
                    pll_lock = 1'b1;
                    rise_cyc = cyc;
                    lock_t   = 0;
                end
            end
            if (dri_ctrl[0]) begin
                req_cnt++;
                req_width++;
                last_ctrl  = dri_ctrl;
                last_wdata = dri_wdata;
                if (ack_delay > 0) pend = ack_delay;
            end else begin
                req_width = 0;
            end
            if (req_width > max_width) max_width = req_width;
        end
    end

    task automatic send_cmd(input bit wr, input logic [8:0] addr, input logic [31:0] data);
        int n = 0;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [1:0] err, output logic [31:0] rdata, output int rcyc);
        int k;
        lat = 1;
        while (!rsp_valid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_seen", rsp_valid, 1);
        rcyc = cyc; err = rsp_err; rdata = rsp_rdata;
        k = $urandom_range(0, 2);
        repeat (k) begin
            @(negedge clk);
            check("rsp_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, err, rdata});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ready_after_rsp", cmd_ready, 1);
        check("rsp_dropped", rsp_valid, 0);
    endtask

    // Reference: expected status/data/latency from the command and the responder's behaviour
    task automatic do_cmd(input bit wr, input logic [8:0] addr, input logic [31:0] data,
                          input int dly, input logic [31:0] adata, input int lmode, input int gap);
        logic [1:0]  e_err = 2'b00, g_err;
        logic [31:0] e_rdata = '0, g_rdata;
        int lo, hi, lat, rcyc, req0;
        bit rise_chk = 1'b0;
        bit local_rd = (!wr && addr == 9'h1FF);
        ack_delay = dly; ack_data = adata; lock_mode = wr ? lmode : 0; lock_gap = gap;
        rise_cyc = -1; req0 = req_cnt;
        if (local_rd) begin
            e_rdata = {31'b0, flag_model}; lo = 1; hi = 1; flag_model = 1'b0;
        end else if (dly == 0 || dly > TO + 1) begin
            e_err = 2'b01; lo = TO + 1; hi = TO + 3;
        end else if (!wr) begin
            e_rdata = adata; lo = dly + 2; hi = dly + 2;
`ifdef PLL_DRI_RELOCK_WAIT_EN
        end else if (lmode == 1) begin
            rise_chk = 1'b1; lo = dly + 2; hi = 3000;
        end else begin
            e_err = 2'b10; lo = dly + 2 + LTO; hi = dly + 4 + LTO;
`else
        end else begin
            lo = dly + 2; hi = dly + 2;
`endif
        end
        send_cmd(wr, addr, data);
        wait_rsp(lat, g_err, g_rdata, rcyc);
        check("rsp_err", g_err, e_err);
        check("rsp_rdata", g_rdata, e_rdata);
        check_range("latency", lat, lo, hi);
        if (rise_chk) check_range("rsp_after_lock_rise", rcyc - rise_cyc, 2, 4);
        if (local_rd) begin
            check("no_dri_txn", req_cnt - req0, 0);
        end else begin
            check("req_count", req_cnt - req0, 1);
            check("dri_ctrl", last_ctrl, {addr, wr, 1'b1});
            if (wr) check("dri_wdata", last_wdata, {1'b1, data});
        end
    endtask

    task automatic pulse_irq();
        dri_interrupt = 1'b1;
        repeat (2) @(negedge clk);
        dri_interrupt = 1'b0;
        flag_model = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, cmd_ready, 0);
        check({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dri"}, {dri_ctrl, dri_wdata}, 0);
    endtask

    initial begin : stim
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        do_cmd(1'b0, 9'h004, 32'h0, 3, 32'hA5A5_0001, 0, 0);
        check("req_width", max_width, 1);
        do_cmd(1'b1, 9'h010, 32'h0000_00F9, 4, 32'h0, 1, 100);
        do_cmd(1'b0, 9'h020, 32'h0, 0, 32'h0, 0, 0);
        do_cmd(1'b0, 9'h030, 32'h0, TO + 1, 32'h1234_5678, 0, 0);
        do_cmd(1'b0, 9'h031, 32'h0, TO + 2, 32'h1234_5678, 0, 0);
        do_cmd(1'b1, 9'h040, 32'hCAFE_0042, 5, 32'h0, 2, 0);
        pll_lock = 1'b1;
        repeat (6) @(negedge clk);

        pulse_irq();
        do_cmd(1'b0, 9'h1FF, 32'h0, 2, 32'h0, 0, 0);
        do_cmd(1'b0, 9'h1FF, 32'h0, 2, 32'h0, 0, 0);

        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        check("stray_ack_ignored", {rsp_valid, busy}, 0);

        // reset while waiting for an ack
        ack_delay = 0;
        send_cmd(1'b0, 9'h055, 32'h0);
        repeat (10) @(negedge clk);
        check("busy_wait_ack", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_wait_ack");
        @(negedge clk);
        rst_n = 1'b1;
        flag_model = 1'b0;
        @(negedge clk);
        // reset during the req cycle clears DRI_CTRL without a clock edge
        send_cmd(1'b1, 9'h066, 32'h0000_0077);
        check("req_live", dri_ctrl, {9'h066, 1'b1, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("ctrl_async_clr", {dri_ctrl, dri_wdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_cmd(1'b0, 9'h070, 32'h0, 6, 32'h0BAD_F00D, 0, 0);

        for (int i = 0; i < 12; i++) begin
            bit          wr = 1'($urandom_range(0, 1));
            logic [8:0]  addr = 9'($urandom_range(0, 510));
            int          dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30);
            if ($urandom_range(0, 4) == 0) begin
                wr = 1'b0;
                addr = 9'h1FF;
                if ($urandom_range(0, 1) == 1) pulse_irq();
            end
            do_cmd(wr, addr, $urandom, dly, $urandom, 1, $urandom_range(10, 120));
            repeat (2) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
